qnigma_mdio_poll: RTL

QNIGMA_MDIO_POLL -- requirements
Module: qnigma_mdio_poll

---
 rtl/qnigma_mdio_pkg.sv | 34 +++
 rtl/qnigma_mdio_txn.sv | 52 +++++
 rtl/qnigma_mdio_poll.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/qnigma_mdio_pkg.sv
// Shared constants and types for the MDIO PHY init/poll controller.
package qnigma_mdio_pkg;

   // Standard clause-22 register addresses
   localparam logic [4:0]  REG_BMCR   = 5'd0;
   localparam logic [4:0]  REG_BMSR   = 5'd1;
   localparam logic [4:0]  REG_PHYID1 = 5'd2;
   localparam logic [4:0]  REG_PHYID2 = 5'd3;

   // BMCR init: soft reset, autoneg enable, full duplex, 1000 Mb/s select
   localparam logic [15:0] BMCR_INIT  = 16'h9140;

   typedef enum logic [3:0] {
      RST_HOLD,
      CFG_WR,
      CFG_CHK,
      RD_ID1,
      RD_ID2,
      NEXT_INIT,
      POLL_WAIT,
      RD_BMSR,
      RD_SPD,
      NEXT_POLL
   } state_t;

   // One MDIO transaction request as seen by the serial engine
   typedef struct packed {
      logic        r_nw;
      logic [4:0]  phyad;
      logic [4:0]  regad;
      logic [15:0] dat;
   } mdio_cmd_t;

endpackage

// File: rtl/qnigma_mdio_txn.sv
// Handshake front end for the MDIO serial engine: one send pulse per request,
// command fields held stable until done, and the outstanding-request flag.
module qnigma_mdio_txn
   import qnigma_mdio_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  mdio_cmd_t   cmd,
   input  logic        ready,
   input  logic        done,
   output logic        send,
   output logic        r_nw,
   output logic [4:0]  phyad,
   output logic [4:0]  regad,
   output logic [15:0] dat_out,
   output logic        pend,
   output logic        fin
);

   logic issue;

   assign issue = req & ready & ~pend;
   // A done with nothing outstanding (e.g. after rst abandoned a transfer) is ignored
   assign fin   = done & pend;

   // Launch a transaction, latch its fields, and retire it on done.
   always_ff @(posedge clk) begin
      if (rst) begin
         send    <= 1'b0;
         pend    <= 1'b0;
         r_nw    <= 1'b1;
         phyad   <= '0;
         regad   <= '0;
         dat_out <= '0;
      end else begin
         // NOTE: flops use <= so every register samples pre-edge values; blocking
         // assignments here would make results depend on statement order.
         send <= issue;
         if (issue) begin
            pend    <= 1'b1;
            r_nw    <= cmd.r_nw;
            phyad   <= cmd.phyad;
            regad   <= cmd.regad;
            dat_out <= cmd.dat;
         end else if (done) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/qnigma_mdio_poll.sv
// PHY bring-up and link poller: holds PHYs in hardware reset, soft-resets and
// identifies each PHY, then periodically polls link state and resolved speed.
module qnigma_mdio_poll
   import qnigma_mdio_pkg::*;
#(
   parameter int N_PHY      = 2,
   parameter int PHY_ADDR0  = 1,
   parameter int RST_TICKS  = 250,
   parameter int POLL_TICKS = 1000,
   parameter int RST_TRIES  = 16,
   parameter int SPD_REG    = 17,
   parameter int SPD_LSB    = 14
)(
   input  logic                 clk,
   input  logic                 rst,
   output logic                 phy_rstn,
   output logic                 send,
   output logic                 r_nw,
   input  logic                 ready,
   input  logic                 done,
   output logic [4:0]           phyad,
   output logic [4:0]           regad,
   output logic [15:0]          dat_out,
   input  logic                 val_in,
   input  logic [15:0]          dat_in,
   input  logic [4:0]           adr_in,
   output logic [N_PHY-1:0]     link_up,
   output logic [2*N_PHY-1:0]   spd,
   output logic [32*N_PHY-1:0]  phyid,
   output logic [N_PHY-1:0]     link_chg,
   output logic [N_PHY-1:0]     init_err
);

   localparam int RST_W  = $clog2(RST_TICKS + 1);
   localparam int POLL_W = $clog2(POLL_TICKS + 1);
   localparam int TRY_W  = $clog2(RST_TRIES + 1);
   localparam int CH_W   = (N_PHY > 1) ? $clog2(N_PHY) : 1;

   state_t              state, state_d;
   logic [CH_W-1:0]     ch, ch_d;
   logic [RST_W-1:0]    rst_cnt, rst_cnt_d;
   logic [POLL_W-1:0]   poll_cnt, poll_cnt_d;
   logic [TRY_W-1:0]    try_cnt, try_cnt_d;
   logic                rstn_d;
   logic                req, pend, fin, set_err, last_ch;
   logic                rd_now, rd_b15, rd_b2, rd_b15_eff, rd_b2_eff;
   mdio_cmd_t           cmd;

   qnigma_mdio_txn u_txn (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .cmd     (cmd),
      .ready   (ready),
      .done    (done),
      .send    (send),
      .r_nw    (r_nw),
      .phyad   (phyad),
      .regad   (regad),
      .dat_out (dat_out),
      .pend    (pend),
      .fin     (fin)
   );

   // Only read data for the outstanding register counts; a same-cycle val_in/done
   // is forwarded so the decision taken on done sees the fresh data.
   assign rd_now     = val_in & pend & r_nw & (adr_in == regad);
   assign rd_b15_eff = rd_now ? dat_in[15] : rd_b15;
   assign rd_b2_eff  = rd_now ? dat_in[2]  : rd_b2;
   assign last_ch    = (int'(ch) == N_PHY - 1);

   // State register and FSM-owned counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RST_HOLD;
         ch       <= '0;
         rst_cnt  <= '0;
         poll_cnt <= '0;
         try_cnt  <= '0;
         phy_rstn <= 1'b0;
      end else begin
         state    <= state_d;
         ch       <= ch_d;
         rst_cnt  <= rst_cnt_d;
         poll_cnt <= poll_cnt_d;
         try_cnt  <= try_cnt_d;
         phy_rstn <= rstn_d;
      end
   end

   // Next-state, counter and transaction-request decode.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_d    = state;
      ch_d       = ch;
      rst_cnt_d  = rst_cnt;
      poll_cnt_d = poll_cnt;
      try_cnt_d  = try_cnt;
      rstn_d     = 1'b1;
      set_err    = 1'b0;
      req        = 1'b0;
      cmd.r_nw   = 1'b1;
      cmd.phyad  = 5'(PHY_ADDR0) + 5'(ch);
      cmd.regad  = REG_BMCR;
      cmd.dat    = '0;
      case (state)
         RST_HOLD: begin
            rstn_d = 1'b0;
            if (int'(rst_cnt) + 1 >= RST_TICKS) begin
               rstn_d    = 1'b1;
               rst_cnt_d = '0;
               ch_d      = '0;
               state_d   = CFG_WR;
            end else begin
               rst_cnt_d = rst_cnt + 1'b1;
            end
         end
         CFG_WR: begin
            req      = 1'b1;
            cmd.r_nw = 1'b0;
            cmd.dat  = BMCR_INIT;
            if (fin) begin
               try_cnt_d = '0;
               state_d   = CFG_CHK;
            end
         end
         CFG_CHK: begin
            req = 1'b1;
            if (fin) begin
               if (!rd_b15_eff) begin
                  try_cnt_d = '0;
                  state_d   = RD_ID1;
               end else if (int'(try_cnt) + 1 >= RST_TRIES) begin
                  try_cnt_d = '0;
                  set_err   = 1'b1;
                  state_d   = NEXT_INIT;
               end else begin
                  try_cnt_d = try_cnt + 1'b1;
               end
            end
         end
         RD_ID1: begin
            req       = 1'b1;
            cmd.regad = REG_PHYID1;
            if (fin) state_d = RD_ID2;
         end
         RD_ID2: begin
            req       = 1'b1;
            cmd.regad = REG_PHYID2;
            if (fin) state_d = NEXT_INIT;
         end
         NEXT_INIT: begin
            if (last_ch) begin
               ch_d    = '0;
               state_d = POLL_WAIT;
            end else begin
               ch_d    = ch + 1'b1;
               state_d = CFG_WR;
            end
         end
         POLL_WAIT: begin
            if (int'(poll_cnt) + 1 >= POLL_TICKS) begin
               poll_cnt_d = '0;
               ch_d       = '0;
               state_d    = RD_BMSR;
            end else begin
               poll_cnt_d = poll_cnt + 1'b1;
            end
         end
         RD_BMSR: begin
            cmd.regad = REG_BMSR;
            if (init_err[ch]) begin
               state_d = NEXT_POLL;
            end else begin
               req = 1'b1;
               if (fin) state_d = rd_b2_eff ? RD_SPD : NEXT_POLL;
            end
         end
         RD_SPD: begin
            req       = 1'b1;
            cmd.regad = 5'(SPD_REG);
            if (fin) state_d = NEXT_POLL;
         end
         NEXT_POLL: begin
            if (last_ch) begin
               state_d = POLL_WAIT;
            end else begin
               ch_d    = ch + 1'b1;
               state_d = RD_BMSR;
            end
         end
         default: state_d = RST_HOLD;
      endcase
   end

   // Read-data capture into per-PHY status; link_chg is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: phyid is a handful of flops, not a RAM, so it is reset like any
         // other register and reads as zero until the PHY has been identified.
         phyid    <= '0;
         link_up  <= '0;
         spd      <= '0;
         link_chg <= '0;
         init_err <= '0;
         rd_b15   <= 1'b0;
         rd_b2    <= 1'b0;
      end else begin
         link_chg <= '0;
         if (set_err) init_err[ch] <= 1'b1;
         if (rd_now) begin
            rd_b15 <= dat_in[15];
            rd_b2  <= dat_in[2];
            case (state)
               RD_ID1:  phyid[int'(ch)*32 + 16 +: 16] <= dat_in;
               RD_ID2:  phyid[int'(ch)*32 +: 16]      <= dat_in;
               RD_BMSR: begin
                  link_up[ch]  <= dat_in[2];
                  link_chg[ch] <= dat_in[2] ^ link_up[ch];
               end
               RD_SPD:  spd[int'(ch)*2 +: 2] <= dat_in[SPD_LSB +: 2];
               default: ;
            endcase
         end
      end
   end

endmodule
